// File: rtl/alu_seq_if.sv
// Operation/result handshake bundle between the decode stage, alu_seq and writeback.
interface alu_seq_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            op_code;
  logic [DATA_WIDTH-1:0] inA;
  logic [DATA_WIDTH-1:0] inB;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  is_zero;
  logic                  carry;

  // Producer of operations and consumer of results
  modport master (
    output in_valid, op_code, inA, inB, out_ready,
    input  in_ready, out_valid, result, is_zero, carry
  );

  // The ALU itself
  modport slave (
    input  in_valid, op_code, inA, inB, out_ready,
    output in_ready, out_valid, result, is_zero, carry
  );
endinterface

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with carry reporting and an iterative shift-add multiply.
module alu_seq #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  alu_seq_if.slave    bus
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(W + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpAnd = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpLda = 4'b0101;
  localparam logic [3:0] OpSub = 4'b1000;
  localparam logic [3:0] OpShl = 4'b1001;
  localparam logic [3:0] OpShr = 4'b1010;
  localparam logic [3:0] OpMul = 4'b1011;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [W-1:0]    result_q, result_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;

  logic [W-1:0]    alu_res;
  logic            alu_carry;
  logic [2*W-1:0]  acc_step;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    prod_lo;
  logic            mul_done;
  logic            slot_free;
  logic            in_ready;
  logic            accept;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = (state_q == StIdle) && slot_free;
  assign accept    = bus.in_valid && in_ready;

  // Single-cycle datapath for every opcode except MUL
  always_comb begin
    alu_res   = bus.inA;
    alu_carry = 1'b0;
    case (bus.op_code)
      OpAdd: {alu_carry, alu_res} = {1'b0, bus.inA} + {1'b0, bus.inB};
      OpAnd: alu_res = bus.inA & bus.inB;
      OpXor: alu_res = bus.inA ^ bus.inB;
      OpLda: alu_res = bus.inB;
      OpSub: begin
        alu_res   = bus.inA - bus.inB;
        alu_carry = bus.inA < bus.inB;
      end
      OpShl: begin
        alu_res   = {bus.inA[W-2:0], 1'b0};
        alu_carry = bus.inA[W-1];
      end
      OpShr: begin
        alu_res   = {1'b0, bus.inA[W-1:1]};
        alu_carry = bus.inA[0];
      end
      default: ;
    endcase
  end

  // One shift-add step; with one step left the product is final this cycle, so it can be
  // written without waiting an extra edge. At count 0 the held product is in acc_q.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = (cnt_q == '0) ? acc_q : acc_step;
    prod_lo  = prod[W-1:0];
    mul_done = (state_q == StMul) && (cnt_q <= CntW'(1));
  end

  // Next-state: FSM, multiplier registers and the output slot
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.op_code == OpMul) begin
            mcand_d  = {{W{1'b0}}, bus.inA};
            mplier_d = bus.inB;
            acc_d    = '0;
            cnt_d    = CntW'(W);
            state_d  = StMul;
          end else begin
            result_d    = alu_res;
            carry_d     = alu_carry;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      StMul: begin
        if (mul_done && slot_free) begin
          result_d    = prod_lo;
          carry_d     = |prod[2*W-1:W];
          zero_d      = (prod_lo == '0);
          out_valid_d = 1'b1;
          acc_d       = prod;
          cnt_d       = '0;
          state_d     = StIdle;
        end else if (cnt_q != '0) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.is_zero   = zero_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors checked with immediate assertions.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_seq_if #(.DATA_WIDTH(8)) bus ();

  alu_seq #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, wait (bounded) until it is accepted, then drop in_valid.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.op_code  = op;
    bus.inA      = a;
    bus.inB      = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_wait", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    check("out_wait", {31'b0, bus.out_valid}, 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [7:0] res, input logic z, input logic c);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({tag, "_result"}, {24'b0, bus.result}, {24'b0, res});
    check({tag, "_zero"}, {31'b0, bus.is_zero}, {31'b0, z});
    check({tag, "_carry"}, {31'b0, bus.carry}, {31'b0, c});
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.op_code  = 4'h0;
    bus.inA      = 8'h00;
    bus.inB      = 8'h00;
    bus.out_ready = 1'b1;

    // Reset values
    #2;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_result", {24'b0, bus.result}, 32'd0);
    check("rst_zero", {31'b0, bus.is_zero}, 32'd0);
    check("rst_carry", {31'b0, bus.carry}, 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // ADD with carry out
    send(4'b0010, 8'hF0, 8'h20);
    check_out("add", 8'h10, 1'b0, 1'b1);

    // Back-to-back SKZ: consume and accept on the same edge
    bus.in_valid = 1'b1;
    bus.op_code  = 4'b0001;
    bus.inA      = 8'h00;
    check("skz0_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    check_out("skz0", 8'h00, 1'b1, 1'b0);
    check("skz1_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.inA = 8'h05;
    tick();
    check_out("skz1", 8'h05, 1'b0, 1'b0);
    check("skz1_ready_after", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;

    // SUB borrow, shifts
    send(4'b1000, 8'h05, 8'h07);
    check_out("sub", 8'hFE, 1'b0, 1'b1);
    send(4'b1001, 8'h81, 8'h00);
    check_out("shl", 8'h02, 1'b0, 1'b1);
    send(4'b1010, 8'h01, 8'h00);
    check_out("shr", 8'h00, 1'b1, 1'b1);

    // Logic ops and LDA, reserved opcode passes A
    send(4'b0011, 8'hCC, 8'hAA);
    check_out("and", 8'h88, 1'b0, 1'b0);
    send(4'b0100, 8'hCC, 8'hAA);
    check_out("xor", 8'h66, 1'b0, 1'b0);
    send(4'b0101, 8'h12, 8'h34);
    check_out("lda", 8'h34, 1'b0, 1'b0);
    send(4'b1110, 8'h5A, 8'hFF);
    check_out("rsvd", 8'h5A, 1'b0, 1'b0);

    // MUL latency; operands changed after accept must not matter
    send(4'b1011, 8'h0F, 8'h11);
    bus.inA = 8'hFF;
    bus.inB = 8'hFF;
    check("mul_ready_0", {31'b0, bus.in_ready}, 32'd0);
    check("mul_busy_0", {31'b0, bus.out_valid}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("mul_ready_%0d", k), {31'b0, bus.in_ready}, 32'd0);
      check($sformatf("mul_busy_%0d", k), {31'b0, bus.out_valid}, 32'd0);
    end
    tick();
    check_out("mul", 8'hFF, 1'b0, 1'b0);

    send(4'b1011, 8'h10, 8'h10);
    wait_out();
    check_out("mul_ovf", 8'h00, 1'b1, 1'b1);

    // Backpressure: drain slot, then stall the consumer
    tick();
    check("drain", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
    send(4'b0010, 8'h01, 8'h02);
    check_out("bp_first", 8'h03, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.op_code  = 4'b0010;
    bus.inA      = 8'h04;
    bus.inB      = 8'h05;
    check("bp_ready_low", {31'b0, bus.in_ready}, 32'd0);
    tick();
    check_out("bp_hold", 8'h03, 1'b0, 1'b0);
    check("bp_ready_still_low", {31'b0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_ready_high", {31'b0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check_out("bp_second", 8'h09, 1'b0, 1'b0);

    // Reset in the middle of a multiply
    send(4'b1011, 8'h03, 8'h03);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rmul_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rmul_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rmul_result", {24'b0, bus.result}, 32'd0);
    check("rmul_zero", {31'b0, bus.is_zero}, 32'd0);
    check("rmul_carry", {31'b0, bus.carry}, 32'd0);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("rmul_no_result_%0d", k), {31'b0, bus.out_valid}, 32'd0);
    end
    send(4'b0010, 8'h01, 8'h01);
    check_out("post_rst_add", 8'h02, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Handshaked, registered successor to the CPU's combinational ALU. It is generalised to `DATA_WIDTH` and a 4-bit opcode, and adds carry reporting and an iterative multiply. Opcodes 0000–0111 keep the existing CPU opcode semantics. The block sits between the decode stage and the accumulator/writeback, with valid/ready handshakes on both sides.

## Interface
- `DATA_WIDTH`, 8, operand/result width (≥2)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  block can accept an operation
- `op_code`  in  4  operation select
- `inA`  in  DATA_WIDTH  operand A (accumulator)
- `inB`  in  DATA_WIDTH  operand B (memory data)
- `out_valid`  out  1  result registers hold an unconsumed result
- `out_ready`  in  1  consumer takes result
- `result`  out  DATA_WIDTH  registered result
- `is_zero`  out  1  registered, `result == 0`
- `carry`  out  1  registered carry/borrow/overflow flag

## Operation
- **Opcodes:**
  - 0000 HLT, 0001 SKZ, 0110 STO, 0111 JMP, 1100–1111 reserved: result = A, carry 0
  - 0010 ADD: {carry, result} = A + B, computed at DATA_WIDTH+1 bits
  - 0011 AND: A & B, carry 0
  - 0100 XOR: A ^ B, carry 0
  - 0101 LDA: result = B, carry 0
  - 1000 SUB: result = A − B mod 2^DATA_WIDTH; carry = 1 iff A < B (borrow)
  - 1001 SHL: result = A << 1; carry = A[MSB]
  - 1010 SHR: logical shift, result = A >> 1; carry = A[0]
  - 1011 MUL: result = low DATA_WIDTH bits of A*B (unsigned); carry = 1 iff high half ≠ 0
- **Flags:** `is_zero` = (result == 0) for every opcode. This is a superset of the SKZ behaviour: for SKZ, is_zero = (A == 0).
- **States:** IDLE and MUL.
  - **IDLE:** `in_ready` = !out_valid || out_ready.
    - On accept (in_valid && in_ready) of a non-MUL op, the result and flags are written to the output registers at that edge.
    - On accept of MUL, latch A and B, clear the 2·DATA_WIDTH accumulator, set counter = DATA_WIDTH, go to MUL.
  - **MUL:** `in_ready` = 0.
    - Each cycle, shift-add one bit of B (LSB first) and decrement the counter.
    - When the counter reaches 0, the product is complete.
    - Write the output registers at the first edge where the product is complete and (!out_valid || out_ready), then return to IDLE.
    - While the output slot is blocked, hold the completed product and stay in MUL.
- **Output slot:**
  - `out_valid` sets when the output registers are written.
  - `out_valid` clears on out_valid && out_ready unless the registers are written in the same edge.
  - `result`, `is_zero`, `carry` are stable while out_valid && !out_ready.
- Inputs are sampled only at accept. Later changes to `inA`, `inB` or `op_code` do not affect an accepted operation.

## Timing
- **Reset** (rst_n low, async): state IDLE, counter 0.
  - Outputs: out_valid 0, result 0, is_zero 0, carry 0.
  - `in_ready` is 1 combinationally during and after reset.
- **Non-MUL latency:** accept at edge N → out_valid = 1 after edge N. Throughput is 1 op/cycle while out_ready = 1.
- **MUL latency:** accept at edge N → out_valid = 1 after edge N+DATA_WIDTH, provided the slot is free. `in_ready` is 0 for cycles N+1 through N+DATA_WIDTH.
- **Simultaneous consume and accept:** consume of the old result and accept of a non-MUL op at the same edge → new result, out_valid stays 1.
- **Reset mid-MUL:** the operation is discarded and no result is produced.
- **in_valid while in_ready = 0:** ignored. The producer must hold the operation until it is accepted.

## Test plan
- ADD A=0xF0, B=0x20, out_ready=1 → one cycle after accept: result 0x10, carry 1, is_zero 0.
- SKZ A=0x00, then SKZ A=0x05 back-to-back → consecutive results 0x00/is_zero 1, then 0x05/is_zero 0. in_ready stays 1 throughout.
- SUB A=0x05, B=0x07 → result 0xFE, carry 1. SHL A=0x81 → result 0x02, carry 1. SHR A=0x01 → result 0x00, carry 1, is_zero 1.
- MUL A=0x0F, B=0x11 → result 0xFF, carry 0, 8 cycles after accept, in_ready 0 during. MUL A=0x10, B=0x10 → result 0x00, carry 1, is_zero 1.
- Backpressure: out_ready=0, ADD 1+2 accepted, second ADD presented → result stays 0x03, in_ready 0. Raise out_ready → second result appears on the next edge.
- Reset mid-MUL: assert rst_n=0 three cycles after accept → out_valid 0, in_ready 1, all outputs 0 immediately. A following ADD 0x01+0x01 → 0x02.
